// File: rtl/fsm_b_sched_pkg.sv
// ----------------------------------------------------------------------------
// fsm_b_sched_pkg
// Shared types and constants for the match-engine scheduler.
//   sched_state_t : scheduler FSM state encoding
//   SCHED_WD_MAX  : number of DRAIN cycles with hit held high before the
//                   scheduler gives up and flags an error
//   SCHED_DW      : width of num / len / seq / hit-count fields
//   sched_len_eff : maps a requested burst length of 0 to 1 beat
// ----------------------------------------------------------------------------
package fsm_b_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN0,
      S_DRAIN,
      S_RESP
   } sched_state_t;

   localparam int unsigned SCHED_WD_MAX = 16;
   localparam int unsigned SCHED_DW     = 4;

   function automatic logic [SCHED_DW-1:0] sched_len_eff(input logic [SCHED_DW-1:0] len);
      return (len == '0) ? SCHED_DW'(1) : len;
   endfunction

endpackage

// File: rtl/fsm_b_sched_if.sv
// ----------------------------------------------------------------------------
// fsm_b_sched_if
// Bundles the requester side, the match-engine side and the response side of
// the scheduler.
//   requester : req, req_num, req_len, req_seq (in), req_pop (out)
//   engine    : mtr_valid, mtr_num, mtr_seq (out), mtr_hit (in)
//   response  : rsp_valid, rsp_id, rsp_hits, rsp_err (out)
//   status    : busy (out)
// Modports:
//   slave  - the scheduler itself
//   master - the environment (requesters + engine)
// ----------------------------------------------------------------------------
interface fsm_b_sched_if
   import fsm_b_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
);

   logic [NREQ-1:0]          req;
   logic [SCHED_DW*NREQ-1:0] req_num;
   logic [SCHED_DW*NREQ-1:0] req_len;
   logic [SCHED_DW*NREQ-1:0] req_seq;
   logic [NREQ-1:0]          req_pop;

   logic                     mtr_valid;
   logic [SCHED_DW-1:0]      mtr_num;
   logic [SCHED_DW-1:0]      mtr_seq;
   logic                     mtr_hit;

   logic                     rsp_valid;
   logic [IDW-1:0]           rsp_id;
   logic [SCHED_DW-1:0]      rsp_hits;
   logic                     rsp_err;

   logic                     busy;

   modport slave (
      input  req, req_num, req_len, req_seq, mtr_hit,
      output req_pop, mtr_valid, mtr_num, mtr_seq,
      output rsp_valid, rsp_id, rsp_hits, rsp_err, busy
   );

   modport master (
      output req, req_num, req_len, req_seq, mtr_hit,
      input  req_pop, mtr_valid, mtr_num, mtr_seq,
      input  rsp_valid, rsp_id, rsp_hits, rsp_err, busy
   );

endinterface

// File: rtl/fsm_b_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Searches req_i starting at
// position ptr_i and wrapping, returning the first requester found.
//   req_i  : N request levels
//   ptr_i  : highest-priority position for this decision
//   gnt_o  : one-hot grant (all zero when nothing is requested)
//   id_o   : encoded grant index (0 when nothing is requested)
//   any_o  : at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic [N-1:0]   gnt_o,
   output logic [IDW-1:0] id_o,
   output logic           any_o
);

   // One extra bit so ptr+offset can exceed N before the wrap for any N.
   logic [IDW:0]   sum;
   logic [IDW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      id_o  = '0;
      any_o = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int off = 0; off < N; off++) begin
         sum = {1'b0, ptr_i} + (IDW+1)'(off);
         if (sum >= (IDW+1)'(N)) begin
            sum = sum - (IDW+1)'(N);
         end
         idx = sum[IDW-1:0];
         if (!any_o && req_i[idx]) begin
            any_o      = 1'b1;
            gnt_o[idx] = 1'b1;
            id_o       = idx;
         end
      end
   end

endmodule

// File: rtl/fsm_b_sched.sv
// ----------------------------------------------------------------------------
// fsm_b_sched
// Round-robin scheduler sharing one sequence-match engine among NREQ
// requesters. A granted requester's burst is streamed into the engine, the
// engine's hit pulses are counted, and the count is returned as a one-cycle
// response tagged with the requester id.
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : fsm_b_sched_if.slave (requester, engine, response, busy)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for any req; arbitrate and latch num/len on grant
// S_STREAM | one beat per cycle into the engine, pop the granted requester
// S_DRAIN0 | valid low for one cycle while the engine resolves the burst
// S_DRAIN  | count hit cycles; leave on first idle cycle or watchdog expiry
// S_RESP   | one-cycle response strobe, advance round-robin pointer
// ----------------------------------------------------------------------------
module fsm_b_sched
   import fsm_b_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic          clock,
   input  logic          reset,
   fsm_b_sched_if.slave  bus
);

   logic [SCHED_DW-1:0] num_a [NREQ];
   logic [SCHED_DW-1:0] len_a [NREQ];
   logic [SCHED_DW-1:0] seq_a [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign num_a[g] = bus.req_num[SCHED_DW*g +: SCHED_DW];
      assign len_a[g] = bus.req_len[SCHED_DW*g +: SCHED_DW];
      assign seq_a[g] = bus.req_seq[SCHED_DW*g +: SCHED_DW];
   end

   sched_state_t        state_q;
   logic [IDW-1:0]      rr_ptr_q;
   logic [IDW-1:0]      gid_q;
   logic [SCHED_DW-1:0] num_q;
   logic [SCHED_DW-1:0] beats_left_q;
   logic [SCHED_DW-1:0] hit_cnt_q;
   logic [SCHED_DW-1:0] wd_left_q;
   logic                err_q;
   logic                mtr_valid_q;
   logic [NREQ-1:0]     pop_q;
   logic                busy_q;
   logic                rsp_valid_q;
   logic [IDW-1:0]      rsp_id_q;
   logic [SCHED_DW-1:0] rsp_hits_q;

   logic [NREQ-1:0]     arb_gnt;
   logic [IDW-1:0]      arb_id;
   logic                arb_any;
   logic [SCHED_DW-1:0] hit_cnt_inc;

   assign hit_cnt_inc = hit_cnt_q + SCHED_DW'(1);

   rr_arbiter #(
      .N   (NREQ),
      .IDW (IDW)
   ) u_arb (
      .req_i (bus.req),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .id_o  (arb_id),
      .any_o (arb_any)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         gid_q        <= '0;
         num_q        <= '0;
         beats_left_q <= '0;
         hit_cnt_q    <= '0;
         wd_left_q    <= '0;
         err_q        <= 1'b0;
         mtr_valid_q  <= 1'b0;
         pop_q        <= '0;
         busy_q       <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_hits_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arb_any) begin
                  gid_q        <= arb_id;
                  num_q        <= num_a[arb_id];
                  // Down-counter: terminal count 0 marks the last beat.
                  beats_left_q <= sched_len_eff(len_a[arb_id]) - SCHED_DW'(1);
                  hit_cnt_q    <= '0;
                  wd_left_q    <= SCHED_DW'(SCHED_WD_MAX - 1);
                  err_q        <= 1'b0;
                  mtr_valid_q  <= 1'b1;
                  pop_q        <= arb_gnt;
                  busy_q       <= 1'b1;
                  state_q      <= S_STREAM;
               end
            end

            S_STREAM: begin
               if (beats_left_q == '0) begin
                  mtr_valid_q <= 1'b0;
                  pop_q       <= '0;
                  state_q     <= S_DRAIN0;
               end else begin
                  beats_left_q <= beats_left_q - SCHED_DW'(1);
               end
            end

            S_DRAIN0: begin
               state_q <= S_DRAIN;
            end

            S_DRAIN: begin
               if (bus.mtr_hit) begin
                  hit_cnt_q <= hit_cnt_inc;
                  // A well-behaved engine never holds hit for 16 cycles;
                  // bail out rather than wait on a stuck engine.
                  if (wd_left_q == '0) begin
                     err_q       <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     rsp_id_q    <= gid_q;
                     rsp_hits_q  <= hit_cnt_inc;
                     state_q     <= S_RESP;
                  end else begin
                     wd_left_q <= wd_left_q - SCHED_DW'(1);
                  end
               end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= gid_q;
                  rsp_hits_q  <= hit_cnt_q;
                  state_q     <= S_RESP;
               end
            end

            S_RESP: begin
               rsp_valid_q <= 1'b0;
               rsp_id_q    <= '0;
               rsp_hits_q  <= '0;
               err_q       <= 1'b0;
               busy_q      <= 1'b0;
               rr_ptr_q    <= (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
               state_q     <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Seq is a pass-through so the beat presented with req_pop is the one
   // the engine samples in the same cycle.
   assign bus.mtr_seq   = mtr_valid_q ? seq_a[gid_q] : '0;
   assign bus.mtr_valid = mtr_valid_q;
   assign bus.mtr_num   = num_q;
   assign bus.req_pop   = pop_q;
   assign bus.busy      = busy_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_hits  = rsp_hits_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_fsm_b_sched.sv
module tb_fsm_b_sched;

   localparam int NREQ = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   fsm_b_sched_if #(.NREQ(NREQ)) bus ();

   fsm_b_sched #(.NREQ(NREQ)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Requester beat feeders: each pop advances that requester's read index.
   logic [3:0] seq_mem [NREQ][16];
   logic [3:0] bidx    [NREQ];

   always @(posedge clock) begin
      for (int i = 0; i < NREQ; i++) begin
         if (reset)               bidx[i] <= 4'd0;
         else if (bus.req_pop[i]) bidx[i] <= bidx[i] + 4'd1;
      end
   end

   always_comb begin
      bus.req_seq = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_seq[4*i +: 4] = seq_mem[i][bidx[i]];
      end
   end

   // Engine model: count matches while valid, then hold hit for k cycles
   // starting two cycles after the last valid beat.
   logic [3:0] eng_cnt;
   logic [3:0] eng_rem;
   logic       eng_v_q;
   logic       force_hit;

   always @(posedge clock) begin
      if (reset) begin
         eng_cnt <= 4'd0;
         eng_rem <= 4'd0;
         eng_v_q <= 1'b0;
      end else begin
         eng_v_q <= bus.mtr_valid;
         if (bus.mtr_valid) begin
            eng_cnt <= eng_cnt + ((bus.mtr_seq == bus.mtr_num) ? 4'd1 : 4'd0);
         end
         if (!bus.mtr_valid && eng_v_q) begin
            eng_rem <= eng_cnt;
            eng_cnt <= 4'd0;
         end else if (eng_rem != 4'd0) begin
            eng_rem <= eng_rem - 4'd1;
         end
      end
   end

   assign bus.mtr_hit = (eng_rem != 4'd0) | force_hit;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int id, input logic [3:0] num, input logic [3:0] len,
                       input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] s3);
      bus.req_num[4*id +: 4] = num;
      bus.req_len[4*id +: 4] = len;
      seq_mem[id][bidx[id]]         = s0;
      seq_mem[id][bidx[id] + 4'd1]  = s1;
      seq_mem[id][bidx[id] + 4'd2]  = s2;
      seq_mem[id][bidx[id] + 4'd3]  = s3;
   endtask

   // Called at the negedge of the grant cycle (cycle 0); returns at the
   // negedge of the IDLE cycle following the response.
   task automatic run_txn(input string tag, input int id, input int npop,
                          input int hit_first, input int nhit,
                          input logic [3:0] hits, input logic err,
                          input int rsp_at, input logic [3:0] num, input bit drop);
      logic [3:0] onehot;
      onehot = 4'b0001 << id;
      for (int c = 1; c <= rsp_at + 1; c++) begin
         @(negedge clock);
         if (c == 1 && drop) bus.req[id] = 1'b0;
         check({tag, "/pop"},   32'(bus.req_pop),   (c <= npop) ? 32'(onehot) : 32'd0);
         check({tag, "/valid"}, 32'(bus.mtr_valid), (c <= npop) ? 32'd1 : 32'd0);
         check({tag, "/busy"},  32'(bus.busy),      (c <= rsp_at) ? 32'd1 : 32'd0);
         check({tag, "/rspv"},  32'(bus.rsp_valid), (c == rsp_at) ? 32'd1 : 32'd0);
         if (c <= rsp_at)
            check({tag, "/hit"}, 32'(bus.mtr_hit),
                  (c >= hit_first && c < hit_first + nhit) ? 32'd1 : 32'd0);
         if (c > npop)
            check({tag, "/seq0"}, 32'(bus.mtr_seq), 32'd0);
         if (c == 1 || c == rsp_at + 1)
            check({tag, "/num"}, 32'(bus.mtr_num), 32'(num));
         if (c == rsp_at) begin
            check({tag, "/id"},   32'(bus.rsp_id),   32'(id));
            check({tag, "/hits"}, 32'(bus.rsp_hits), 32'(hits));
            check({tag, "/err"},  32'(bus.rsp_err),  32'(err));
         end else begin
            check({tag, "/rsp0"}, 32'({bus.rsp_id, bus.rsp_hits, bus.rsp_err}), 32'd0);
         end
      end
   endtask

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      bus.req     = '0;
      bus.req_num = '0;
      bus.req_len = '0;
      force_hit   = 1'b0;
      for (int i = 0; i < NREQ; i++)
         for (int j = 0; j < 16; j++)
            seq_mem[i][j] = 4'd0;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst/busy",  32'(bus.busy),      32'd0);
      check("rst/pop",   32'(bus.req_pop),   32'd0);
      check("rst/valid", 32'(bus.mtr_valid), 32'd0);
      check("rst/rspv",  32'(bus.rsp_valid), 32'd0);
      check("rst/num",   32'(bus.mtr_num),   32'd0);
      check("rst/seq",   32'(bus.mtr_seq),   32'd0);
      reset = 1'b0;

      // Single burst: num 5, seq 5,3,5,5 -> 3 hits in cycles 6..8, rsp at 10
      load(0, 4'd5, 4'd4, 4'd5, 4'd3, 4'd5, 4'd5);
      bus.req[0] = 1'b1;
      run_txn("single", 0, 4, 6, 3, 4'd3, 1'b0, 10, 4'd5, 1'b1);

      // Zero match: rsp at grant+6, no hits
      load(2, 4'd7, 4'd3, 4'd1, 4'd2, 4'd3, 4'd0);
      bus.req[2] = 1'b1;
      run_txn("zero", 2, 3, 0, 0, 4'd0, 1'b0, 6, 4'd7, 1'b1);

      // len 0 treated as one beat
      load(1, 4'd4, 4'd0, 4'd4, 4'd0, 4'd0, 4'd0);
      bus.req[1] = 1'b1;
      run_txn("len0", 1, 1, 3, 1, 4'd1, 1'b0, 5, 4'd4, 1'b1);

      // Watchdog: hit stuck high; 16 DRAIN cycles from cycle 4, rsp at 20
      load(3, 4'd9, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0);
      force_hit  = 1'b1;
      bus.req[3] = 1'b1;
      run_txn("wdog", 3, 2, 1, 20, 4'd0, 1'b1, 20, 4'd9, 1'b1);
      force_hit  = 1'b0;

      // Round robin with all four held high: grants 0,1,2,3,0
      load(0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0);
      load(1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0);
      load(2, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0);
      load(3, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0);
      bus.req = 4'b1111;
      run_txn("rr0", 0, 1, 3, 1, 4'd1, 1'b0, 5, 4'd1, 1'b0);
      run_txn("rr1", 1, 1, 3, 1, 4'd1, 1'b0, 5, 4'd1, 1'b0);
      run_txn("rr2", 2, 1, 3, 1, 4'd1, 1'b0, 5, 4'd1, 1'b0);
      run_txn("rr3", 3, 1, 3, 1, 4'd1, 1'b0, 5, 4'd1, 1'b0);
      run_txn("rr4", 0, 1, 3, 1, 4'd1, 1'b0, 5, 4'd1, 1'b0);
      bus.req = 4'b0000;

      // Reset during STREAM (pointer is 1 here, so requester 1 wins)
      load(1, 4'd6, 4'd4, 4'd6, 4'd6, 4'd6, 4'd6);
      bus.req = 4'b0010;
      @(negedge clock);
      check("mid/pop1", 32'(bus.req_pop), 32'b0010);
      @(negedge clock);
      check("mid/pop2", 32'(bus.req_pop), 32'b0010);
      reset   = 1'b1;
      bus.req = 4'b0000;
      @(negedge clock);
      check("mid/busy",  32'(bus.busy),      32'd0);
      check("mid/pop",   32'(bus.req_pop),   32'd0);
      check("mid/valid", 32'(bus.mtr_valid), 32'd0);
      check("mid/rspv",  32'(bus.rsp_valid), 32'd0);
      check("mid/num",   32'(bus.mtr_num),   32'd0);
      reset = 1'b0;

      // Pointer back at 0: with req 3 and 0 pending, 0 must win
      load(0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0);
      load(3, 4'd8, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);
      bus.req = 4'b1001;
      run_txn("postrst", 0, 2, 4, 2, 4'd2, 1'b0, 7, 4'd2, 1'b1);
      bus.req = 4'b0000;

      @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/fsm_b_sched.md
Name: fsm_b_sched

Overview:
- Round-robin scheduler that shares one sequence-match engine among NREQ requesters.
- Per transaction: grants one requester, latches its target `num` and burst length, streams its `seq` beats into the engine as a valid burst, then counts the engine's `hit` pulses.
- Returns the hit count to the granted requester as a one-cycle response.
- Sits between requester agents and the match engine; it is the engine's only driver.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), requester-id width.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request level, sampled only in IDLE
- req_num  in  4*NREQ  packed target value; slice i belongs to requester i
- req_len  in  4*NREQ  packed burst length in beats; 0 is treated as 1
- req_seq  in  4*NREQ  packed current seq beat; must be valid while the corresponding req_pop bit is high
- req_pop  out  NREQ  one-hot; beat consumed this cycle
- mtr_valid  out  1  engine valid
- mtr_num  out  4  engine num
- mtr_seq  out  4  engine seq
- mtr_hit  in  1  engine hit
- rsp_valid  out  1  response strobe, one cycle
- rsp_id  out  IDW  requester id of the response
- rsp_hits  out  4  hits counted, mod 16
- rsp_err  out  1  drain watchdog fired
- busy  out  1  state != IDLE

Behaviour:
- Engine contract:
  - While valid=1, the engine counts beats with seq==num.
  - Its first hit cycle is 2 cycles after the last valid beat.
  - hit then stays high for exactly k consecutive cycles (k = match count mod 16); k=0 means no hit.
- States:
  - IDLE: if |req, pick the winner round-robin starting at rr_ptr. Latch gid, num_q, len_q (0→1). Clear beat_cnt and hit_cnt. Go to STREAM next cycle. Else stay.
  - STREAM:
    - Outputs: mtr_valid=1, mtr_seq=req_seq[gid], req_pop[gid]=1; beat_cnt++.
    - Exit: when beat_cnt==len_q-1, go to DRAIN0.
  - DRAIN0: mtr_valid=0, one cycle (engine resolves). Go to DRAIN.
  - DRAIN:
    - If mtr_hit: hit_cnt++ and wd_cnt++; stay.
    - Else: go to RESP.
    - If wd_cnt reaches 16 with hit still high: go to RESP with err_q=1.
  - RESP: rsp_valid=1, rsp_id=gid, rsp_hits=hit_cnt, rsp_err=err_q. rr_ptr←gid+1 mod NREQ. Go to IDLE.
- Latency: one burst of L beats with k hits gives rsp_valid L+k+3 cycles after the grant cycle; k=0 gives L+3.
- mtr_num=num_q in all states and holds between transactions.
- mtr_seq=0 outside STREAM.
- req_pop=0 outside STREAM.
- rsp_* are 0 whenever rsp_valid=0.
- A req deasserted after grant is ignored; the transaction completes.
- A new req arriving during busy waits; no pre-emption.
- hit_cnt is 4-bit and wraps 15→0.
- mtr_hit outside DRAIN is ignored.
- Reset (any state, including mid-burst):
  - state=IDLE, rr_ptr=0, all outputs 0, counters cleared, err_q=0.
  - The engine shares the same reset.
- Minimum one IDLE cycle between transactions guarantees the engine is in WAIT before the next valid.

Decomposition:
- In the shared sys_defs package:
  - typedef SCHED_STATE {S_IDLE, S_STREAM, S_DRAIN0, S_DRAIN, S_RESP}.
  - Constant SCHED_WD_MAX=16.
- Sub-module rr_arbiter (NREQ-wide req + pointer → one-hot grant and encoded id, purely combinational). It is reusable.
- The FSM, counters and muxes stay in fsm_b_sched.

Test Plan:
- Single burst: req[0] with num=5, len=4, seq 5,3,5,5 (grant cycle 0).
  - req_pop[0] high in cycles 1–4.
  - mtr_hit in cycles 6–8.
  - rsp_valid at cycle 10 with id=0, hits=3, err=0.
- Zero match: req[2] with num=7, len=3, seq 1,2,3.
  - mtr_hit never high.
  - rsp at grant+6 with hits=0.
- len=0: req[1] with num=4, len=0, seq 4.
  - Exactly one pop.
  - rsp hits=1.
- Round-robin fairness: all four req held high continuously.
  - Grant order 0,1,2,3,0.
  - rsp_id follows the same sequence.
  - No grant while busy=1.
- Watchdog: engine model forces hit high indefinitely after the burst.
  - rsp after 16 DRAIN cycles with err=1, hits=0 (wrapped).
  - Next transaction proceeds normally.
- Reset mid-STREAM: assert reset at the 2nd beat.
  - The following cycle: busy=0, req_pop=0, mtr_valid=0, rsp_valid=0.
  - rr_ptr=0, so req[3] and req[0] both pending gives grant 0.
